// File: rtl/pps_qualifier_pkg.sv
// Shared definitions for the PPS qualifier: FSM state encoding, status
// widths and default timing constants for a 10 MHz major clock with a
// 1 Hz GPS PPS.
package pps_qualifier_pkg;

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } state_t;

    localparam int unsigned REJECT_W = 8;

    localparam int unsigned DEF_NOMINAL_PERIOD = 10_000_000;
    localparam int unsigned DEF_TOLERANCE      = 1_000;
    localparam int unsigned DEF_MIN_HIGH       = 100;
    localparam int unsigned DEF_LOCK_COUNT     = 4;
    localparam int unsigned DEF_OUT_HIGH       = 16;
    localparam int unsigned DEF_CNT_WIDTH      = 25;

endpackage

// File: rtl/pps_glitch_filter.sv
// Glitch filter for the synchronized PPS level: counts consecutive high
// cycles and strobes candidate for one cycle when the count reaches
// MIN_HIGH. Shorter high phases never strobe.
// Ports: clk, rst_n (async active-low), level (synchronized PPS),
//        candidate (registered one-cycle strobe).
module pps_glitch_filter #(
    parameter int unsigned MIN_HIGH = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic candidate
);

    localparam int unsigned HW = $clog2(MIN_HIGH + 1);

    logic [HW-1:0] high_cnt;

    // Counter saturates at MIN_HIGH so a long high phase yields one strobe only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_cnt  <= '0;
            candidate <= 1'b0;
        end else if (!level) begin
            high_cnt  <= '0;
            candidate <= 1'b0;
        end else begin
            if (high_cnt != HW'(MIN_HIGH)) begin
                high_cnt <= high_cnt + HW'(1);
            end
            candidate <= (high_cnt == HW'(MIN_HIGH - 1));
        end
    end

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pps_qualifier.sv
// PPS qualifier: synchronizes the raw GPS PPS to MAJOR_CLOCK, filters
// glitches, accepts only edges inside the period window and emits a
// fixed-latency pulse plus lock / missing status.
// Ports: MAJOR_CLOCK (clock), RESET_N (async active-low reset),
//        PPS_IN (raw PPS), PPS_OUT (qualified pulse, OUT_HIGH cycles),
//        LOCKED (LOCK_COUNT consecutive accepts), MISSING (timeout seen,
//        cleared by next accept), REJECT_CNT (saturating early-edge count).
module pps_qualifier
    import pps_qualifier_pkg::*;
#(
    parameter int unsigned NOMINAL_PERIOD = DEF_NOMINAL_PERIOD,
    parameter int unsigned TOLERANCE      = DEF_TOLERANCE,
    parameter int unsigned MIN_HIGH       = DEF_MIN_HIGH,
    parameter int unsigned LOCK_COUNT     = DEF_LOCK_COUNT,
    parameter int unsigned OUT_HIGH       = DEF_OUT_HIGH,
    parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                MAJOR_CLOCK,
    input  logic                RESET_N,
    input  logic                PPS_IN,
    output logic                PPS_OUT,
    output logic                LOCKED,
    output logic                MISSING,
    output logic [REJECT_W-1:0] REJECT_CNT
);

    localparam int unsigned OW = $clog2(OUT_HIGH + 1);
    localparam int unsigned LW = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_WIDTH-1:0] WIN_LO  = CNT_WIDTH'(NOMINAL_PERIOD - TOLERANCE);
    localparam logic [CNT_WIDTH-1:0] WIN_HI  = CNT_WIDTH'(NOMINAL_PERIOD + TOLERANCE);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT = CNT_WIDTH'(NOMINAL_PERIOD + TOLERANCE + 1);

    logic                 pps_sync;
    logic                 candidate;
    state_t               state;
    logic [CNT_WIDTH-1:0] period_cnt;
    logic [LW-1:0]        consec;
    logic [OW-1:0]        out_cnt;
    logic                 in_window;
    logic                 early;

    sync_2ff u_sync (
        .clk   (MAJOR_CLOCK),
        .rst_n (RESET_N),
        .d     (PPS_IN),
        .q     (pps_sync)
    );

    pps_glitch_filter #(
        .MIN_HIGH (MIN_HIGH)
    ) u_filter (
        .clk       (MAJOR_CLOCK),
        .rst_n     (RESET_N),
        .level     (pps_sync),
        .candidate (candidate)
    );

    assign in_window = (period_cnt >= WIN_LO) && (period_cnt <= WIN_HI);
    assign early     = (period_cnt < WIN_LO);

    // FSM, period counter, output pulse timer and status registers.
    always_ff @(posedge MAJOR_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ACQUIRE;
            period_cnt <= '0;
            consec     <= '0;
            out_cnt    <= '0;
            PPS_OUT    <= 1'b0;
            LOCKED     <= 1'b0;
            MISSING    <= 1'b0;
            REJECT_CNT <= '0;
        end else begin
            // Pulse timer runs down; an accept below restarts it.
            if (out_cnt != '0) begin
                out_cnt <= out_cnt - OW'(1);
            end else begin
                PPS_OUT <= 1'b0;
            end

            case (state)
                ACQUIRE: begin
                    if (candidate) begin
                        state      <= TRACK;
                        period_cnt <= CNT_WIDTH'(1);
                        consec     <= '0;
                        LOCKED     <= 1'b0;
                    end
                end

                TRACK: begin
                    period_cnt <= period_cnt + CNT_WIDTH'(1);
                    if (candidate && in_window) begin
                        period_cnt <= CNT_WIDTH'(1);
                        PPS_OUT    <= 1'b1;
                        out_cnt    <= OW'(OUT_HIGH - 1);
                        MISSING    <= 1'b0;
                        if (consec != LW'(LOCK_COUNT)) begin
                            consec <= consec + LW'(1);
                        end
                        // Registered view of the post-increment count.
                        LOCKED     <= (consec >= LW'(LOCK_COUNT - 1));
                    end else if (candidate && early) begin
                        if (REJECT_CNT != '1) begin
                            REJECT_CNT <= REJECT_CNT + REJECT_W'(1);
                        end
                    end else if (period_cnt >= TIMEOUT) begin
                        state      <= ACQUIRE;
                        period_cnt <= '0;
                        consec     <= '0;
                        LOCKED     <= 1'b0;
                        MISSING    <= 1'b1;
                    end
                end

                default: state <= ACQUIRE;
            endcase
        end
    end

endmodule
